even_parity_serial_tx: RTL



---
 rtl/even_parity_serial_tx_pkg.sv | 22 ++
 rtl/even_parity_serial_tx_if.sv | 31 +++
 rtl/even_parity_serial_tx_bit_timer.sv | 35 +++
 rtl/even_parity_serial_tx.sv | 104 ++++++++++
 4 files changed

// File: rtl/even_parity_serial_tx_pkg.sv
// Shared types and constants for the even-parity serial transmitter.
// Optional parity-error injection is enabled by defining TX_PARITY_INJECT_EN.
package even_parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a 0..range-1 count, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_if.sv
// Valid/ready word-input channel of the even-parity serial transmitter.
// inject_err is present only when TX_PARITY_INJECT_EN is defined.
interface even_parity_serial_tx_if #(
  parameter int unsigned DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
`ifdef TX_PARITY_INJECT_EN
  logic              inject_err;
`endif

  modport master (
    output in_valid,
    output in_data,
`ifdef TX_PARITY_INJECT_EN
    output inject_err,
`endif
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef TX_PARITY_INJECT_EN
    input  inject_err,
`endif
    output in_ready
  );

endinterface

// File: rtl/even_parity_serial_tx_bit_timer.sv
// Bit-period timer: bit_done pulses on the last cycle of each CLKS_PER_BIT period.
module bit_timer
  import even_parity_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_done
);

  localparam int unsigned    CntW    = cnt_w(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!run || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/even_parity_serial_tx.sv
// Frames a DATA_W-bit word as start, data LSB-first, even parity, stop and shifts it out.
// Defining TX_PARITY_INJECT_EN adds inject_err, which inverts the sent parity bit.
module even_parity_serial_tx
  import even_parity_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  even_parity_serial_tx_if.slave  in_if,
  output logic                    tx_serial,
  output logic                    busy,
  output logic                    parity_out
);

  localparam int unsigned     BitW    = cnt_w(DATA_W);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              bit_done;
  logic              accept;
  logic              inject;

`ifdef TX_PARITY_INJECT_EN
  assign inject = in_if.inject_err;
`else
  assign inject = 1'b0;
`endif

  assign in_if.in_ready = (state_q == IDLE) && rst_n;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign busy           = (state_q != IDLE);
  assign parity_out     = parity_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (busy),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_serial = LINE_IDLE;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d  = in_if.in_data;
          parity_d = (^in_if.in_data) ^ inject;
          state_d  = START;
        end
      end
      START: begin
        tx_serial = START_BIT;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        tx_serial = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      PARITY: begin
        tx_serial = parity_q;
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        tx_serial = STOP_BIT;
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
    end
  end

endmodule
